// File: rtl/gpio_irq.sv
// GPIO peripheral: per-pin direction, atomic set/clear/toggle, synchronised inputs, edge interrupts.
// Optional per-pin input debounce is compiled in when GPIO_DEBOUNCE_EN is defined.
module gpio_irq #(
  parameter int GPIO_NUM    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  input  logic [GPIO_NUM-1:0] io_pin_i,
  output logic [GPIO_NUM-1:0] io_out_o,
  output logic [GPIO_NUM-1:0] io_oe_o,
  output logic                irq_o
);

  localparam logic [3:0] REG_DIR  = 4'h0;
  localparam logic [3:0] REG_OUT  = 4'h1;
  localparam logic [3:0] REG_IN   = 4'h2;
  localparam logic [3:0] REG_SET  = 4'h3;
  localparam logic [3:0] REG_CLR  = 4'h4;
  localparam logic [3:0] REG_TGL  = 4'h5;
  localparam logic [3:0] REG_RISE = 4'h6;
  localparam logic [3:0] REG_FALL = 4'h7;
  localparam logic [3:0] REG_STAT = 4'h8;
  localparam logic [3:0] REG_DB   = 4'h9;

  if (GPIO_NUM < 1 || GPIO_NUM > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DB_CNT_W < 1 || DB_CNT_W > 32) begin : g_bad_params
    $error("gpio_irq: parameter out of legal range");
  end

  logic [3:0]          wsel;
  logic [GPIO_NUM-1:0] wdata;
  logic [GPIO_NUM-1:0] dir_reg;
  logic [GPIO_NUM-1:0] out_reg;
  logic [GPIO_NUM-1:0] rise_en_reg;
  logic [GPIO_NUM-1:0] fall_en_reg;
  logic [GPIO_NUM-1:0] stat_reg;
  logic [GPIO_NUM-1:0] stat_next;
  logic [GPIO_NUM-1:0] prev_in_reg;
  logic [GPIO_NUM-1:0] in_val;
  logic [GPIO_NUM-1:0] sync_out;
  logic [GPIO_NUM-1:0] w1c;
  logic [SYNC_STAGES-1:0][GPIO_NUM-1:0] sync_reg;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign wsel        = addr_i[5:2];
  assign wdata       = data_i[GPIO_NUM-1:0];
  assign unused_bits = ^{addr_i[31:6], addr_i[1:0], data_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], io_pin_i};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_cfg_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cfg_reg <= '0;
    end else if (we_i && wsel == REG_DB) begin
      db_cfg_reg <= data_i[DB_CNT_W-1:0];
    end
  end

  // Any sample that agrees with IN restarts the count, so glitches never accumulate.
  for (genvar gi = 0; gi < GPIO_NUM; gi++) begin : g_db
    logic [DB_CNT_W-1:0] cnt_reg;
    logic                in_bit_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg    <= '0;
        in_bit_reg <= 1'b0;
      end else if (sync_out[gi] == in_bit_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == db_cfg_reg) begin
        in_bit_reg <= sync_out[gi];
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign in_val[gi] = in_bit_reg;
  end
`else
  assign in_val = sync_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_reg     <= '0;
      out_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
    end else if (we_i) begin
      case (wsel)
        REG_DIR:  dir_reg     <= wdata;
        REG_OUT:  out_reg     <= wdata;
        REG_SET:  out_reg     <= out_reg | wdata;
        REG_CLR:  out_reg     <= out_reg & ~wdata;
        REG_TGL:  out_reg     <= out_reg ^ wdata;
        REG_RISE: rise_en_reg <= wdata;
        REG_FALL: fall_en_reg <= wdata;
        default:  ;
      endcase
    end
  end

  // New edges are OR-ed in after the clear, so a same-cycle edge keeps the bit set.
  assign w1c       = (we_i && wsel == REG_STAT) ? wdata : '0;
  assign stat_next = (stat_reg & ~w1c)
                   | (in_val & ~prev_in_reg & rise_en_reg)
                   | (~in_val & prev_in_reg & fall_en_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_in_reg <= '0;
      stat_reg    <= '0;
    end else begin
      prev_in_reg <= in_val;
      stat_reg    <= stat_next;
    end
  end

  always_comb begin
    rdata = '0;
    case (wsel)
      REG_DIR:  rdata = 32'(dir_reg);
      REG_OUT:  rdata = 32'(out_reg);
      REG_IN:   rdata = 32'(in_val);
      REG_RISE: rdata = 32'(rise_en_reg);
      REG_FALL: rdata = 32'(fall_en_reg);
      REG_STAT: rdata = 32'(stat_reg);
`ifdef GPIO_DEBOUNCE_EN
      REG_DB:   rdata = 32'(db_cfg_reg);
`endif
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
    end else if (!we_i) begin
      data_o <= rdata;
    end
  end

  assign io_out_o = out_reg;
  assign io_oe_o  = dir_reg;
  assign irq_o    = |stat_reg;

endmodule
